// File: rtl/card_list_reader.sv
// Walks a linked list of cards in a ram1024x32 and streams each card out
// over a valid/ready handshake; read-only, aborts on a free word or runaway list.
module card_list_reader #(
   parameter int MAX_CARDS = 52,
   parameter int CNT_W     = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [9:0]       head_addr,
   output logic [9:0]       ram_addr,
   input  logic [31:0]      ram_q,
   output logic             card_valid,
   input  logic             card_ready,
   output logic [3:0]       card_value,
   output logic [1:0]       card_suit,
   output logic [9:0]       card_addr,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [2:0] {IDLE, FETCH, READ, PRESENT, FINISH} state_t;

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CARDS);

   state_t     state;
   logic [9:0] cur;
   logic [9:0] nxt;

   // Reserved-zero fields of the card word are not interpreted.
   logic unused_ram_bits;
   assign unused_ram_bits = ^{ram_q[30:22], ram_q[15:10]};

   // ram_addr is loaded on entry to FETCH so the address is on the RAM
   // during FETCH and the word comes back during READ.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         cur        <= '0;
         nxt        <= '0;
         ram_addr   <= '0;
         card_valid <= 1'b0;
         card_value <= '0;
         card_suit  <= '0;
         card_addr  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         count      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cur   <= head_addr;
                  count <= '0;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  if (head_addr == 10'd0) begin
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     ram_addr <= head_addr;
                     state    <= FETCH;
                  end
               end
            end
            FETCH: state <= READ;
            READ: begin
               if (!ram_q[31]) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  state <= FINISH;
               end else begin
                  card_value <= ram_q[19:16];
                  card_suit  <= ram_q[21:20];
                  card_addr  <= cur;
                  nxt        <= ram_q[9:0];
                  card_valid <= 1'b1;
                  state      <= PRESENT;
               end
            end
            PRESENT: begin
               if (card_ready) begin
                  card_valid <= 1'b0;
                  count      <= count + 1'b1;
                  if (nxt == 10'd0) begin
                     done  <= 1'b1;
                     state <= FINISH;
                  end else if (count + 1'b1 == MAX_CNT) begin
                     // Loop guard: a cyclic or corrupt list stops here.
                     error <= 1'b1;
                     done  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     cur      <= nxt;
                     ram_addr <= nxt;
                     state    <= FETCH;
                  end
               end
            end
            FINISH: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_list_reader.sv
// Bench for card_list_reader: directed table of walks, stall and reset
// sequences, then random lists checked against a list-walking reference model.
module tb_card_list_reader;

   localparam int MAXC = 52;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic [9:0]  head_addr;
   logic [9:0]  ram_addr;
   logic [31:0] ram_q;
   logic        card_valid;
   logic        card_ready;
   logic [3:0]  card_value;
   logic [1:0]  card_suit;
   logic [9:0]  card_addr;
   logic        busy;
   logic        done;
   logic        error;
   logic [5:0]  count;

   card_list_reader #(.MAX_CARDS(MAXC), .CNT_W(6)) dut (
      .clock(clock), .resetn(resetn), .start(start), .head_addr(head_addr),
      .ram_addr(ram_addr), .ram_q(ram_q), .card_valid(card_valid),
      .card_ready(card_ready), .card_value(card_value), .card_suit(card_suit),
      .card_addr(card_addr), .busy(busy), .done(done), .error(error),
      .count(count)
   );

   always #5 clock = ~clock;

   logic [31:0] mem [1024];
   always @(posedge clock) ram_q <= mem[ram_addr];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cw(input bit a, input logic [1:0] s,
                                      input logic [3:0] v, input logic [9:0] nx);
      return {a, 9'd0, s, v, 6'd0, nx};
   endfunction

   // Expected card stream as {addr, suit, value}
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   bit          exp_err;

   task automatic model(input logic [9:0] head);
      logic [9:0] c;
      int n;
      exp_q.delete();
      exp_err = 1'b0;
      c = head;
      n = 0;
      while (c != 10'd0) begin
         if (!mem[c][31]) begin exp_err = 1'b1; break; end
         exp_q.push_back({c, mem[c][21:20], mem[c][19:16]});
         n++;
         if (mem[c][9:0] == 10'd0) break;
         if (n == MAXC) begin exp_err = 1'b1; break; end
         c = mem[c][9:0];
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: hold off 4 cycles per card
   task automatic run_walk(input logic [9:0] head, input int mode,
                           output int done_cyc, output int first_v);
      logic [15:0] held;
      bit stalled;
      int stall;
      got_q.delete();
      done_cyc = -1;
      first_v  = -1;
      stall    = 0;
      stalled  = 1'b0;
      held     = '0;
      @(negedge clock);
      start      = 1'b1;
      head_addr  = head;
      card_ready = (mode == 0);
      for (int c = 1; c <= 1000; c++) begin
         @(negedge clock);
         start = 1'b0;
         if (c == 1 && head != 10'd0) chk("ram_addr_cycle1", ram_addr, head);
         if (card_valid) begin
            if (first_v < 0) first_v = c;
            if (stalled) chk("stall_stable", {card_addr, card_suit, card_value}, held);
            held = {card_addr, card_suit, card_value};
         end
         if (done) begin done_cyc = c; break; end
         case (mode)
            0:       card_ready = 1'b1;
            1:       card_ready = 1'($urandom_range(0, 1));
            default: card_ready = card_valid && (stall >= 4);
         endcase
         stall   = (card_valid && !card_ready) ? stall + 1 : 0;
         stalled = card_valid && !card_ready;
         if (card_valid && card_ready) got_q.push_back({card_addr, card_suit, card_value});
      end
      card_ready = 1'b0;
      if (done_cyc < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic check_result(input string tag);
      chk({tag, "_ncards"}, got_q.size(), exp_q.size());
      chk({tag, "_count"}, count, exp_q.size());
      chk({tag, "_error"}, error, exp_err);
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk({tag, "_card"}, got_q[i], exp_q[i]);
      @(negedge clock);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_idle"}, busy, 0);
      @(negedge clock);
      chk({tag, "_error_hold"}, error, exp_err);
      chk({tag, "_count_hold"}, count, exp_q.size());
   endtask

   typedef struct {
      logic [9:0] head;
      int mode;
      int exp_count;
      int exp_err;
      int exp_done;   // -1: not timed
      int exp_first;  // -1: card_valid never high
   } vec_t;

   vec_t tbl[5];
   int dc, fv;

   initial begin
      tbl[0] = '{10'd0,  0, 0,  0, 1,   -1};
      tbl[1] = '{10'd5,  0, 2,  0, 7,   3};
      tbl[2] = '{10'd5,  2, 2,  0, -1,  3};
      tbl[3] = '{10'd20, 0, 0,  1, 3,   -1};
      tbl[4] = '{10'd7,  0, 52, 1, 157, 3};

      for (int i = 0; i < 1024; i++) mem[i] = '0;
      mem[5]  = cw(1'b1, 2'd2, 4'd12, 10'd9);
      mem[9]  = cw(1'b1, 2'd0, 4'd1, 10'd0);
      mem[20] = cw(1'b0, 2'd3, 4'd5, 10'd9);
      mem[7]  = cw(1'b1, 2'd1, 4'd3, 10'd7);

      resetn = 1'b0; start = 1'b0; head_addr = '0; card_ready = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_card_valid", card_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_count", count, 0);
      chk("rst_ram_addr", ram_addr, 0);
      resetn = 1'b1;

      for (int i = 0; i < 5; i++) begin
         model(tbl[i].head);
         run_walk(tbl[i].head, tbl[i].mode, dc, fv);
         chk("tbl_count", count, tbl[i].exp_count);
         chk("tbl_error", error, tbl[i].exp_err);
         chk("tbl_first_valid", fv, tbl[i].exp_first);
         if (tbl[i].exp_done >= 0) chk("tbl_done_cycle", dc, tbl[i].exp_done);
         check_result("tbl");
      end

      // Reset while a card is being presented, then re-walk from the head
      @(negedge clock);
      start = 1'b1; head_addr = 10'd5; card_ready = 1'b0;
      @(negedge clock);
      start = 1'b0;
      for (int c = 0; c < 20 && !card_valid; c++) @(negedge clock);
      chk("pre_reset_valid", card_valid, 1);
      #2 resetn = 1'b0;
      #1;
      chk("async_rst_valid", card_valid, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_count", count, 0);
      @(negedge clock);
      resetn = 1'b1;
      model(10'd5);
      run_walk(10'd5, 0, dc, fv);
      chk("rewalk_done_cycle", dc, 7);
      check_result("rewalk");

      // Random lists: normal, one free word, or a cycle back into the list
      for (int t = 0; t < 40; t++) begin
         logic [9:0] addrs[$];
         bit used[1024];
         int n, kind;
         for (int i = 0; i < 1024; i++) begin mem[i] = '0; used[i] = 1'b0; end
         n = $urandom_range(1, 8);
         kind = $urandom_range(0, 3);
         addrs.delete();
         while (addrs.size() < n) begin
            logic [9:0] a;
            a = 10'($urandom_range(1, 1023));
            if (!used[a]) begin used[a] = 1'b1; addrs.push_back(a); end
         end
         for (int i = 0; i < n; i++)
            mem[addrs[i]] = cw(1'b1, 2'($urandom), 4'($urandom),
                               (i == n - 1) ? 10'd0 : addrs[i + 1]);
         if (kind == 2) mem[addrs[$urandom_range(0, n - 1)]][31] = 1'b0;
         if (kind == 3) mem[addrs[n - 1]][9:0] = addrs[$urandom_range(0, n - 1)];
         model(addrs[0]);
         run_walk(addrs[0], 1, dc, fv);
         check_result("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
